// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB plus IO wait and
// resumable HALT, with handshakes to imem, dmem and board I/O.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   instr, instr_valid  instruction word and its valid (FETCH only)
//   mem_ready           data-memory completion (MEM only)
//   alu_zero            ALU zero flag (EXEC of BEQ/BNE only)
//   in_valid, out_ack   board input present / display accepted (IO only)
//   resume              leave HALT
//   fetch_req           request instruction at current PC
//   opcode              ir[31:26]
//   alu_op/alu_src/rsrc ALU function, operand select, read-reg select
//   wsrc, reg_write     write-back source (00 ALU, 01 mem, 10 input) + strobe
//   mem_read/mem_write  held in MEM until mem_ready
//   out_valid           held in IO until out_ack
//   pc_write, pc_src    retirement strobe and next-PC select
//   halted, state       HALT flag and encoded state
//   retired             wrapping count of pc_write strobes
module multicycle_control_fsm #(
    parameter int ALUOP_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               instr_valid,
    input  logic               mem_ready,
    input  logic               alu_zero,
    input  logic               in_valid,
    input  logic               out_ack,
    input  logic               resume,
    output logic               fetch_req,
    output logic [5:0]         opcode,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         alu_src,
    output logic [1:0]         rsrc,
    output logic [1:0]         wsrc,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               out_valid,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               halted,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_IO     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_FORMAT1 = 6'b000000;
    localparam logic [5:0] OP_JUMP    = 6'b010000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_SUBI    = 6'b001001;
    localparam logic [5:0] OP_BEQ     = 6'b001010;
    localparam logic [5:0] OP_BNE     = 6'b001011;
    localparam logic [5:0] OP_LR      = 6'b001100;
    localparam logic [5:0] OP_SR      = 6'b001101;
    localparam logic [5:0] OP_IN      = 6'b001110;
    localparam logic [5:0] OP_OUT     = 6'b001111;
    localparam logic [5:0] OP_LI      = 6'b011000;
    localparam logic [5:0] OP_HALT    = 6'b111001;

    localparam logic [ALUOP_W-1:0] AOP_DEF = ALUOP_W'(6'b001011);
    localparam logic [ALUOP_W-1:0] AOP_ADD = ALUOP_W'(6'b000000);
    localparam logic [ALUOP_W-1:0] AOP_SUB = ALUOP_W'(6'b000001);
    localparam logic [ALUOP_W-1:0] AOP_BNE = ALUOP_W'(6'b001110);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [31:0]          ir_q;
    logic [CNT_W-1:0]     retired_q;
    logic                 fetch_req_q;
    logic [ALUOP_W-1:0]   alu_op_q;
    logic [1:0]           alu_src_q;
    logic [1:0]           rsrc_q;
    logic [1:0]           wsrc_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic                 out_valid_q;
    logic                 halted_q;

    logic                 retire_d;
    logic                 reg_write_d;
    logic [1:0]           pc_src_d;

    logic [5:0] op;
    logic is_f1, is_jump, is_addi, is_subi, is_beq, is_bne;
    logic is_lr, is_sr, is_in, is_out, is_li, is_halt;
    logic is_alu;

    assign op      = ir_q[31:26];
    assign is_f1   = (op == OP_FORMAT1);
    assign is_jump = (op == OP_JUMP);
    assign is_addi = (op == OP_ADDI);
    assign is_subi = (op == OP_SUBI);
    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_lr   = (op == OP_LR);
    assign is_sr   = (op == OP_SR);
    assign is_in   = (op == OP_IN);
    assign is_out  = (op == OP_OUT);
    assign is_li   = (op == OP_LI);
    assign is_halt = (op == OP_HALT);
    assign is_alu  = is_f1 | is_addi | is_subi | is_li;

    // Middle IR bits belong to the datapath (register fields, immediates).
    logic unused_ir;
    assign unused_ir = ^ir_q;

    // Completion strobes must coincide with the handshake input that ends
    // the state, so they are decoded from the current state and inputs.
    always_comb begin
        state_d     = state_q;
        retire_d    = 1'b0;
        reg_write_d = 1'b0;
        pc_src_d    = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_in || is_out) begin
                    state_d = S_IO;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu) begin
                    state_d = S_WB;
                end else if (is_lr || is_sr) begin
                    state_d = S_MEM;
                end else begin
                    // Branches, jump and every NOP-class opcode end here.
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                    if (is_beq) begin
                        pc_src_d = {1'b0, alu_zero};
                    end else if (is_bne) begin
                        pc_src_d = {1'b0, ~alu_zero};
                    end else if (is_jump) begin
                        pc_src_d = 2'b10;
                    end
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_lr) begin
                        state_d = S_WB;
                    end else begin
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write_d = 1'b1;
                retire_d    = 1'b1;
                state_d     = S_FETCH;
            end
            S_IO: begin
                if (is_in) begin
                    if (in_valid) begin
                        reg_write_d = 1'b1;
                        retire_d    = 1'b1;
                        state_d     = S_FETCH;
                    end
                end else if (out_ack) begin
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_HALT: begin
                if (resume) begin
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // Reset aborts the instruction: nothing may retire or write back.
        if (rst) begin
            retire_d    = 1'b0;
            reg_write_d = 1'b0;
            pc_src_d    = 2'b00;
        end
    end

    // Registered outputs describe the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            retired_q   <= '0;
            fetch_req_q <= 1'b1;
            alu_op_q    <= AOP_DEF;
            alu_src_q   <= 2'b00;
            rsrc_q      <= 2'b00;
            wsrc_q      <= 2'b00;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && instr_valid) begin
                ir_q <= instr;
            end
            if (retire_d) begin
                retired_q <= retired_q + CNT_ONE;
            end

            fetch_req_q <= (state_d == S_FETCH);
            halted_q    <= (state_d == S_HALT);
            mem_read_q  <= (state_d == S_MEM) && is_lr;
            mem_write_q <= (state_d == S_MEM) && is_sr;
            out_valid_q <= (state_d == S_IO) && is_out;

            if (state_d == S_WB && is_lr) begin
                wsrc_q <= 2'b01;
            end else if (state_d == S_IO && is_in) begin
                wsrc_q <= 2'b10;
            end else begin
                wsrc_q <= 2'b00;
            end

            alu_op_q  <= AOP_DEF;
            alu_src_q <= 2'b00;
            rsrc_q    <= 2'b00;
            if (state_d == S_EXEC) begin
                if (is_f1) begin
                    alu_op_q <= ir_q[ALUOP_W-1:0];
                    rsrc_q   <= 2'b01;
                end else if (is_addi) begin
                    alu_op_q  <= AOP_ADD;
                    alu_src_q <= 2'b01;
                end else if (is_subi) begin
                    alu_op_q  <= AOP_SUB;
                    alu_src_q <= 2'b01;
                end else if (is_li || is_lr || is_sr) begin
                    alu_src_q <= 2'b01;
                end else if (is_beq) begin
                    alu_op_q <= AOP_SUB;
                end else if (is_bne) begin
                    alu_op_q <= AOP_BNE;
                end
            end
        end
    end

    assign fetch_req = fetch_req_q;
    assign opcode    = op;
    assign alu_op    = alu_op_q;
    assign alu_src   = alu_src_q;
    assign rsrc      = rsrc_q;
    assign wsrc      = wsrc_q;
    assign reg_write = reg_write_d;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign out_valid = out_valid_q;
    assign pc_write  = retire_d;
    assign pc_src    = pc_src_d;
    assign halted    = halted_q;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each issued instruction
// queues its expected retirement; a negedge monitor checks every pc_write.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ack = 1'b0;
    logic        resume = 1'b0;

    logic        fetch_req;
    logic [5:0]  opcode;
    logic [5:0]  alu_op;
    logic [1:0]  alu_src, rsrc, wsrc, pc_src;
    logic        reg_write, mem_read, mem_write, out_valid, pc_write, halted;
    logic [2:0]  state;
    logic [3:0]  retired;

    multicycle_control_fsm #(.ALUOP_W(6), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .alu_zero(alu_zero), .in_valid(in_valid),
        .out_ack(out_ack), .resume(resume), .fetch_req(fetch_req),
        .opcode(opcode), .alu_op(alu_op), .alu_src(alu_src), .rsrc(rsrc),
        .wsrc(wsrc), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .out_valid(out_valid), .pc_write(pc_write),
        .pc_src(pc_src), .halted(halted), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] ws;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] model_cnt = 4'd0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ret(input logic [2:0] st, input logic [1:0] pcs,
                              input logic rw, input logic [1:0] ws);
        exp_t e;
        e.st  = st;
        e.pcs = pcs;
        e.rw  = rw;
        e.ws  = ws;
        e.cnt = model_cnt;
        sb.push_back(e);
        model_cnt = model_cnt + 4'd1;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (state !== 3'd0 && n < 64) begin
            step();
            n++;
        end
        if (state !== 3'd0) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: state %0d want 0", state);
        end
    endtask

    task automatic fetch(input logic [5:0] op, input logic [25:0] rest);
        wait_fetch();
        instr = {op, rest};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr = 32'hdead_beef;
    endtask

    always @(negedge clk) begin
        if (!rst && pc_write === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: pc_write 1 want 0");
            end else begin
                mon_e = sb.pop_front();
                chk("ret_state", 32'(state), 32'(mon_e.st));
                chk("ret_pc_src", 32'(pc_src), 32'(mon_e.pcs));
                chk("ret_reg_write", 32'(reg_write), 32'(mon_e.rw));
                chk("ret_wsrc", 32'(wsrc), 32'(mon_e.ws));
                chk("ret_count", 32'(retired), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int sc;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_state", 32'(state), 0);
        chk("rst_fetch_req", 32'(fetch_req), 1);
        chk("rst_alu_op", 32'(alu_op), 32'h0b);
        chk("rst_strobes", 32'({pc_write, reg_write, mem_read,
                                mem_write, out_valid, halted}), 0);
        chk("rst_selects", 32'({alu_src, rsrc, wsrc, pc_src}), 0);
        chk("rst_retired", 32'(retired), 0);

        // SR aborted by reset in MEM while mem_ready also arrives
        fetch(6'b001101, 26'h10);
        chk("sr_decode", 32'(state), 1);
        step();
        chk("sr_exec_src", 32'(alu_src), 1);
        step();
        chk("sr_mem_write", 32'(mem_write), 1);
        step();
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("sr_rst_no_retire", 32'(pc_write), 0);
        step();
        rst = 1'b0;
        mem_ready = 1'b0;
        chk("sr_rst_state", 32'(state), 0);
        chk("sr_rst_mem_write", 32'(mem_write), 0);
        chk("sr_rst_retired", 32'(retired), 0);

        // ADDI: states 0,1,2,4
        expect_ret(3'd4, 2'b00, 1'b1, 2'b00);
        fetch(6'b001000, 26'h5);
        chk("addi_decode", 32'(state), 1);
        chk("addi_d_strobe", 32'({reg_write, pc_write}), 0);
        step();
        chk("addi_exec", 32'(state), 2);
        chk("addi_alu_op", 32'(alu_op), 0);
        chk("addi_alu_src", 32'(alu_src), 1);
        chk("addi_e_strobe", 32'({reg_write, pc_write}), 0);
        step();
        chk("addi_wb", 32'(state), 4);
        chk("addi_wb_strobe", 32'({reg_write, pc_write}), 3);
        step();
        chk("addi_back", 32'(state), 0);
        chk("addi_retired", 32'(retired), 1);

        // LR with mem_ready on the fourth MEM cycle
        expect_ret(3'd4, 2'b00, 1'b1, 2'b01);
        fetch(6'b001100, 26'h22);
        step();
        step();
        chk("lr_mem", 32'(state), 3);
        cnt = 0;
        sc = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            if (mem_read) cnt++;
            if (reg_write) sc++;
            step();
        end
        mem_ready = 1'b0;
        chk("lr_mem_read_cycles", 32'(cnt), 4);
        chk("lr_mem_reg_write", 32'(sc), 0);
        chk("lr_wb", 32'(state), 4);
        chk("lr_wb_mem_read", 32'(mem_read), 0);
        step();
        chk("lr_back", 32'(state), 0);

        // BEQ taken, BNE not taken, JUMP
        expect_ret(3'd2, 2'b01, 1'b0, 2'b00);
        fetch(6'b001010, 26'h3);
        step();
        alu_zero = 1'b1;
        chk("beq_exec", 32'(state), 2);
        chk("beq_alu_op", 32'(alu_op), 1);
        step();
        alu_zero = 1'b0;
        chk("beq_back", 32'(state), 0);

        expect_ret(3'd2, 2'b00, 1'b0, 2'b00);
        fetch(6'b001011, 26'h3);
        step();
        alu_zero = 1'b1;
        chk("bne_alu_op", 32'(alu_op), 32'h0e);
        step();
        alu_zero = 1'b0;
        chk("bne_back", 32'(state), 0);

        expect_ret(3'd2, 2'b10, 1'b0, 2'b00);
        fetch(6'b010000, 26'h100);
        step();
        step();

        // FORMAT1 passes funct through
        expect_ret(3'd4, 2'b00, 1'b1, 2'b00);
        fetch(6'b000000, 26'h25);
        step();
        chk("f1_alu_op", 32'(alu_op), 32'h25);
        chk("f1_rsrc", 32'(rsrc), 1);
        step();
        step();

        // IN waits 10 cycles; stray out_ack must not matter
        expect_ret(3'd5, 2'b00, 1'b1, 2'b10);
        fetch(6'b001110, 26'h0);
        step();
        cnt = 0;
        sc = 0;
        out_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (state == 3'd5) cnt++;
            if (reg_write || pc_write) sc++;
            step();
        end
        out_ack = 1'b0;
        chk("in_io_cycles", 32'(cnt), 10);
        chk("in_no_strobes", 32'(sc), 0);
        in_valid = 1'b1;
        #1;
        chk("in_reg_write", 32'(reg_write), 1);
        chk("in_wsrc", 32'(wsrc), 2);
        step();
        in_valid = 1'b0;
        chk("in_back", 32'(state), 0);

        // OUT held until ack
        expect_ret(3'd5, 2'b00, 1'b0, 2'b00);
        fetch(6'b001111, 26'h0);
        step();
        chk("out_valid_held", 32'(out_valid), 1);
        step();
        step();
        out_ack = 1'b1;
        chk("out_valid_ack", 32'(out_valid), 1);
        step();
        out_ack = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 0);
        chk("out_back", 32'(state), 0);

        // resume in FETCH is ignored
        wait_fetch();
        resume = 1'b1;
        step();
        step();
        resume = 1'b0;
        chk("resume_fetch_state", 32'(state), 0);
        chk("resume_fetch_count", 32'(retired), 32'(model_cnt));

        // HALT until resume
        expect_ret(3'd6, 2'b00, 1'b0, 2'b00);
        fetch(6'b111001, 26'h0);
        step();
        chk("halt_state", 32'(state), 6);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (halted && !pc_write && !fetch_req) cnt++;
            step();
        end
        chk("halt_hold", 32'(cnt), 5);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("halt_resume_state", 32'(state), 0);
        chk("halt_resume_flag", 32'(halted), 0);

        // SR completes immediately
        expect_ret(3'd3, 2'b00, 1'b0, 2'b00);
        fetch(6'b001101, 26'h8);
        step();
        step();
        mem_ready = 1'b1;
        chk("sr_mem_write_ready", 32'(mem_write), 1);
        step();
        mem_ready = 1'b0;
        chk("sr_back", 32'(state), 0);

        // NOP-class retirements carry the 4-bit counter through 15 -> 0
        for (int i = 0; i < 8; i++) begin
            expect_ret(3'd2, 2'b00, 1'b0, 2'b00);
            if (i % 2 == 0) fetch(6'b111000, 26'h0);
            else fetch(6'b110011, 26'h0);
        end
        wait_fetch();
        chk("wrap_retired", 32'(retired), 2);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
